// File: rtl/ddrx_bank_tracker.sv
// Per-bank row-state tracker and ACT/PRE command generator for the DDRx controller.
// Holds open row and tRCD/tRP/tRAS timers per bank and drains all banks for refresh.
module ddrx_bank_tracker #(
  parameter int unsigned C_BANK_WIDTH  = 3,
  parameter int unsigned C_ROW_WIDTH   = 16,
  parameter int unsigned C_TIMER_WIDTH = 6,
  parameter int unsigned C_TRCD        = 4,
  parameter int unsigned C_TRP         = 4,
  parameter int unsigned C_TRAS        = 10
) (
  input  logic                          core_clk,
  input  logic                          core_arstn,
  input  logic                          req_valid,
  input  logic [C_BANK_WIDTH-1:0]       req_bank,
  input  logic [C_ROW_WIDTH-1:0]        req_row,
  output logic                          req_ready,
  output logic                          cmd_valid,
  output logic [1:0]                    cmd_op,
  output logic [C_BANK_WIDTH-1:0]       cmd_bank,
  output logic [C_ROW_WIDTH-1:0]        cmd_row,
  input  logic                          cmd_ready,
  input  logic                          ref_req,
  output logic                          ref_ack,
  output logic [(2**C_BANK_WIDTH)-1:0]  open_mask
);

  localparam int unsigned N = 2 ** C_BANK_WIDTH;
  localparam logic [C_TIMER_WIDTH-1:0] TRCD_LOAD = C_TIMER_WIDTH'(C_TRCD - 1);
  localparam logic [C_TIMER_WIDTH-1:0] TRP_LOAD  = C_TIMER_WIDTH'(C_TRP - 1);
  localparam logic [C_TIMER_WIDTH-1:0] TRAS_LOAD = C_TIMER_WIDTH'(C_TRAS - 1);
  localparam logic [C_TIMER_WIDTH-1:0] TIMER_ONE = C_TIMER_WIDTH'(1);
  localparam logic [1:0] OP_NOP = 2'd0;
  localparam logic [1:0] OP_ACT = 2'd1;
  localparam logic [1:0] OP_PRE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_ACTIVATING  = 2'd1,
    ST_ACTIVE      = 2'd2,
    ST_PRECHARGING = 2'd3
  } bank_state_e;

  bank_state_e              state_q    [N];
  bank_state_e              state_d    [N];
  logic [C_ROW_WIDTH-1:0]   open_row_q [N];
  logic [C_ROW_WIDTH-1:0]   open_row_d [N];
  logic [C_TIMER_WIDTH-1:0] trcd_trp_q [N];
  logic [C_TIMER_WIDTH-1:0] trcd_trp_d [N];
  logic [C_TIMER_WIDTH-1:0] tras_q     [N];
  logic [C_TIMER_WIDTH-1:0] tras_d     [N];

  logic                     cmd_valid_q, cmd_valid_d;
  logic [1:0]               cmd_op_q, cmd_op_d;
  logic [C_BANK_WIDTH-1:0]  cmd_bank_q, cmd_bank_d;
  logic [C_ROW_WIDTH-1:0]   cmd_row_q, cmd_row_d;
  logic [N-1:0]             open_mask_q, open_mask_d;

  logic [N-1:0]             eff_idle, eff_active, tras_ok;
  logic                     cmd_hs, act_pending, pre_found;
  logic [C_BANK_WIDTH-1:0]  pre_bank;

  assign cmd_hs      = cmd_valid_q & cmd_ready;
  assign act_pending = cmd_valid_q & (cmd_op_q == OP_ACT);

  // A bank whose timer reaches 0 this cycle already counts as being in its next state.
  always_comb begin
    eff_idle   = '0;
    eff_active = '0;
    tras_ok    = '0;
    for (int unsigned b = 0; b < N; b++) begin
      eff_idle[b]   = (state_q[b] == ST_IDLE) ||
                      ((state_q[b] == ST_PRECHARGING) && (trcd_trp_q[b] == '0));
      eff_active[b] = (state_q[b] == ST_ACTIVE) ||
                      ((state_q[b] == ST_ACTIVATING) && (trcd_trp_q[b] == '0));
      tras_ok[b]    = (tras_q[b] <= TIMER_ONE);
    end
  end

  assign req_ready = req_valid & ~ref_req & eff_active[req_bank] &
                     (open_row_q[req_bank] == req_row);
  // An ACT still in flight means a bank is about to open, so refresh must wait.
  assign ref_ack   = ref_req & (&eff_idle) & ~act_pending;

  // Per-bank next state: handshakes override timer expiry.
  always_comb begin
    open_mask_d = '0;
    for (int unsigned b = 0; b < N; b++) begin
      state_d[b]    = state_q[b];
      open_row_d[b] = open_row_q[b];
      trcd_trp_d[b] = (trcd_trp_q[b] != '0) ? (trcd_trp_q[b] - TIMER_ONE) : '0;
      tras_d[b]     = (tras_q[b] != '0) ? (tras_q[b] - TIMER_ONE) : '0;
      case (state_q[b])
        ST_ACTIVATING:  if (trcd_trp_q[b] == '0) state_d[b] = ST_ACTIVE;
        ST_PRECHARGING: if (trcd_trp_q[b] == '0) state_d[b] = ST_IDLE;
        default: ;
      endcase
      if (cmd_hs && (cmd_bank_q == C_BANK_WIDTH'(b))) begin
        if (cmd_op_q == OP_ACT) begin
          state_d[b]    = ST_ACTIVATING;
          trcd_trp_d[b] = TRCD_LOAD;
          tras_d[b]     = TRAS_LOAD;
          open_row_d[b] = cmd_row_q;
        end else if (cmd_op_q == OP_PRE) begin
          state_d[b]    = ST_PRECHARGING;
          trcd_trp_d[b] = TRP_LOAD;
        end
      end
      open_mask_d[b] = (state_d[b] == ST_ACTIVATING) || (state_d[b] == ST_ACTIVE);
    end
  end

  // Lowest-index bank that may be precharged now.
  always_comb begin
    pre_found = 1'b0;
    pre_bank  = '0;
    for (int b = int'(N) - 1; b >= 0; b--) begin
      if (eff_active[b] && tras_ok[b]) begin
        pre_found = 1'b1;
        pre_bank  = C_BANK_WIDTH'(b);
      end
    end
  end

  // Command decision; only taken while no command is outstanding.
  always_comb begin
    cmd_valid_d = cmd_valid_q;
    cmd_op_d    = cmd_op_q;
    cmd_bank_d  = cmd_bank_q;
    cmd_row_d   = cmd_row_q;
    if (cmd_hs) begin
      cmd_valid_d = 1'b0;
      cmd_op_d    = OP_NOP;
      cmd_bank_d  = '0;
      cmd_row_d   = '0;
    end
    if (!cmd_valid_q) begin
      if (ref_req) begin
        if (pre_found) begin
          cmd_valid_d = 1'b1;
          cmd_op_d    = OP_PRE;
          cmd_bank_d  = pre_bank;
          cmd_row_d   = '0;
        end
      end else if (req_valid) begin
        if (eff_idle[req_bank]) begin
          cmd_valid_d = 1'b1;
          cmd_op_d    = OP_ACT;
          cmd_bank_d  = req_bank;
          cmd_row_d   = req_row;
        end else if (eff_active[req_bank] && tras_ok[req_bank] &&
                     (open_row_q[req_bank] != req_row)) begin
          cmd_valid_d = 1'b1;
          cmd_op_d    = OP_PRE;
          cmd_bank_d  = req_bank;
          cmd_row_d   = '0;
        end
      end
    end
  end

  always_ff @(posedge core_clk or negedge core_arstn) begin
    if (!core_arstn) begin
      for (int unsigned b = 0; b < N; b++) begin
        state_q[b]    <= ST_IDLE;
        open_row_q[b] <= '0;
        trcd_trp_q[b] <= '0;
        tras_q[b]     <= '0;
      end
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= OP_NOP;
      cmd_bank_q  <= '0;
      cmd_row_q   <= '0;
      open_mask_q <= '0;
    end else begin
      for (int unsigned b = 0; b < N; b++) begin
        state_q[b]    <= state_d[b];
        open_row_q[b] <= open_row_d[b];
        trcd_trp_q[b] <= trcd_trp_d[b];
        tras_q[b]     <= tras_d[b];
      end
      cmd_valid_q <= cmd_valid_d;
      cmd_op_q    <= cmd_op_d;
      cmd_bank_q  <= cmd_bank_d;
      cmd_row_q   <= cmd_row_d;
      open_mask_q <= open_mask_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_op    = cmd_op_q;
  assign cmd_bank  = cmd_bank_q;
  assign cmd_row   = cmd_row_q;
  assign open_mask = open_mask_q;

endmodule
